vga_sync_gen: RTL and testbench

Raster timing generator for the VGA output path. Divides `sys_clk` into a pixel tick and runs horizontal/vertical counters. Produces registered `hsync`, `vsync`, `video_on`, `x` and `y`, which directly drive the pixel generator stage, plus a `frame_start` strobe the character/physics logic uses to latch `char_x`/`char_y` once per frame. Default timing is 640x480@60 from a 100 MHz `sys_clk`.

---
 rtl/vga_timing_pkg.sv | 30 +++
 rtl/pixel_tick_gen.sv | 30 +++
 rtl/vga_sync_gen.sv | 86 ++++++++
 tb/tb_vga_sync_gen.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants and sync-window helpers shared by the
// timing generator, the pixel generator and the testbench.
package vga_timing_pkg;

    localparam int VGA_H_DISPLAY    = 640;
    localparam int VGA_H_FRONT      = 16;
    localparam int VGA_H_SYNC       = 96;
    localparam int VGA_H_BACK       = 48;
    localparam int VGA_V_DISPLAY    = 480;
    localparam int VGA_V_FRONT      = 10;
    localparam int VGA_V_SYNC       = 2;
    localparam int VGA_V_BACK       = 33;
    localparam int VGA_CLK_DIV      = 4;
    localparam bit VGA_SYNC_POL     = 1'b0;
    localparam int VGA_SCREEN_WIDTH = 10;

    localparam int VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    // Sync windows are half-open: [start, end)
    localparam int VGA_H_SYNC_START = VGA_H_DISPLAY + VGA_H_FRONT;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
    localparam int VGA_V_SYNC_START = VGA_V_DISPLAY + VGA_V_FRONT;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

    function automatic logic in_window(input int pos, input int lo, input int hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides sys_clk by CLK_DIV; tick is high during the last cycle of each
// division period so the consumer advances on that edge.
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    output logic tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] div_cnt;

    // With CLK_DIV=1 the counter sits at zero and tick is permanently high.
    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_ONE;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: h/v position counters plus registered sync,
// video_on and frame_start, all aligned to the presented x/y.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY    = VGA_H_DISPLAY,
    parameter int H_FRONT      = VGA_H_FRONT,
    parameter int H_SYNC       = VGA_H_SYNC,
    parameter int H_BACK       = VGA_H_BACK,
    parameter int V_DISPLAY    = VGA_V_DISPLAY,
    parameter int V_FRONT      = VGA_V_FRONT,
    parameter int V_SYNC       = VGA_V_SYNC,
    parameter int V_BACK       = VGA_V_BACK,
    parameter int CLK_DIV      = VGA_CLK_DIV,
    parameter bit SYNC_POL     = VGA_SYNC_POL,
    parameter int SCREEN_WIDTH = VGA_SCREEN_WIDTH
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    output logic                    p_tick,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    video_on,
    output logic [SCREEN_WIDTH-1:0] x,
    output logic [SCREEN_WIDTH-1:0] y,
    output logic                    frame_start
);

    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_DISPLAY + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_DISPLAY + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [SCREEN_WIDTH-1:0] H_LAST = SCREEN_WIDTH'(H_TOTAL - 1);
    localparam logic [SCREEN_WIDTH-1:0] V_LAST = SCREEN_WIDTH'(V_TOTAL - 1);
    localparam logic [SCREEN_WIDTH-1:0] ONE    = SCREEN_WIDTH'(1);

    logic                    tick;
    logic [SCREEN_WIDTH-1:0] x_next;
    logic [SCREEN_WIDTH-1:0] y_next;

    pixel_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_pixel_tick_gen (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .tick     (tick)
    );

    always_comb begin
        x_next = x;
        y_next = y;
        if (tick) begin
            if (x == H_LAST) begin
                x_next = '0;
                y_next = (y == V_LAST) ? '0 : y + ONE;
            end else begin
                x_next = x + ONE;
            end
        end
    end

    // Decode from x_next/y_next so the registered flags line up with x/y.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            x           <= H_LAST;
            y           <= V_LAST;
            video_on    <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            p_tick      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            x           <= x_next;
            y           <= y_next;
            video_on    <= (int'(x_next) < H_DISPLAY) && (int'(y_next) < V_DISPLAY);
            hsync       <= in_window(int'(x_next), HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
            vsync       <= in_window(int'(y_next), VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
            p_tick      <= tick;
            frame_start <= tick && (x_next == '0) && (y_next == '0);
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three instances (default, CLK_DIV=1/positive sync,
// tiny raster) checked against an arithmetic model of the edge count.
module tb_vga_sync_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       video_on;
        logic       hsync;
        logic       vsync;
        logic       p_tick;
        logic       frame_start;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n = 0;
    int   vectors = 0;
    int   miscompares = 0;

    logic       a_p_tick, a_hsync, a_vsync, a_video_on, a_frame_start;
    logic [9:0] a_x, a_y;
    logic       b_p_tick, b_hsync, b_vsync, b_video_on, b_frame_start;
    logic [9:0] b_x, b_y;
    logic       c_p_tick, c_hsync, c_vsync, c_video_on, c_frame_start;
    logic [9:0] c_x, c_y;

    obs_t obs_a, obs_b, obs_c, ea, eb, ec;
    assign obs_a = {a_x, a_y, a_video_on, a_hsync, a_vsync, a_p_tick, a_frame_start};
    assign obs_b = {b_x, b_y, b_video_on, b_hsync, b_vsync, b_p_tick, b_frame_start};
    assign obs_c = {c_x, c_y, c_video_on, c_hsync, c_vsync, c_p_tick, c_frame_start};

    vga_sync_gen dut_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .p_tick(a_p_tick), .hsync(a_hsync),
        .vsync(a_vsync), .video_on(a_video_on), .x(a_x), .y(a_y), .frame_start(a_frame_start)
    );

    vga_sync_gen #(.CLK_DIV(1), .SYNC_POL(1'b1)) dut_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .p_tick(b_p_tick), .hsync(b_hsync),
        .vsync(b_vsync), .video_on(b_video_on), .x(b_x), .y(b_y), .frame_start(b_frame_start)
    );

    vga_sync_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(5), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .CLK_DIV(3), .SYNC_POL(1'b0), .SCREEN_WIDTH(10)
    ) dut_c (
        .sys_clk(clk), .sys_rst_n(rst_n), .p_tick(c_p_tick), .hsync(c_hsync),
        .vsync(c_vsync), .video_on(c_video_on), .x(c_x), .y(c_y), .frame_start(c_frame_start)
    );

    initial forever #5 clk = ~clk;

    // n = sys_clk edges since reset release; k = n/d advances taken so far.
    // Position index p walks the raster in scan order starting one step
    // before (0,0), which is the blanking corner the reset parks at.
    function automatic obs_t model(input int nn, input int d, input int ht, input int vt,
                                   input int hd, input int vd, input int hss, input int hsw,
                                   input int vss, input int vsw, input bit pol);
        obs_t o;
        int k, p, px, py;
        k = nn / d;
        p = (k + ht * vt - 1) % (ht * vt);
        px = p % ht;
        py = p / ht;
        o.x = 10'(px);
        o.y = 10'(py);
        o.video_on = (px < hd) && (py < vd);
        o.hsync = (px >= hss && px < hss + hsw) ? pol : !pol;
        o.vsync = (py >= vss && py < vss + vsw) ? pol : !pol;
        o.p_tick = (nn > 0) && (nn % d == 0);
        o.frame_start = o.p_tick && (p == 0);
        return o;
    endfunction

    function automatic obs_t model_a(input int nn);
        return model(nn, 4, 800, 525, 640, 480, 656, 96, 490, 2, 1'b0);
    endfunction
    function automatic obs_t model_b(input int nn);
        return model(nn, 1, 800, 525, 640, 480, 656, 96, 490, 2, 1'b1);
    endfunction
    function automatic obs_t model_c(input int nn);
        return model(nn, 3, 15, 9, 8, 5, 10, 3, 6, 2, 1'b0);
    endfunction

    task automatic apply_reset(input int hold);
        rst_n = 1'b0;
        n = 0;
        repeat (hold) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) n++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        n = 0;
        repeat (2) @(negedge clk);
        vectors++;
        if (obs_a !== model_a(0)) begin
            miscompares++;
            $display("FAIL reset_a got=%h exp=%h", obs_a, model_a(0));
        end
        vectors++;
        if (obs_b !== model_b(0)) begin
            miscompares++;
            $display("FAIL reset_b got=%h exp=%h", obs_b, model_b(0));
        end
        vectors++;
        if (a_x !== 10'd799 || a_y !== 10'd524 || a_hsync !== 1'b1 || a_vsync !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_const x=%0d y=%0d hs=%b vs=%b exp 799 524 1 1", a_x, a_y, a_hsync, a_vsync);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            ea = model_a(n);
            vectors++;
            if (obs_a !== ea) begin
                miscompares++;
                $display("FAIL startup_a n=%0d got=%h exp=%h", n, obs_a, ea);
            end
            if (n == 4) begin
                vectors++;
                if (!(a_frame_start === 1'b1 && a_p_tick === 1'b1 && a_x === 10'd0 &&
                      a_y === 10'd0 && a_video_on === 1'b1)) begin
                    miscompares++;
                    $display("FAIL first_advance fs=%b pt=%b x=%0d y=%0d vo=%b exp 1 1 0 0 1",
                             a_frame_start, a_p_tick, a_x, a_y, a_video_on);
                end
            end
        end
    endtask

    task automatic test_line();
        int ticks = 0, hs_cyc = 0, hs_adv = 0, vo_cyc = 0, fall_n = -1, b_hs_hi = 0, b_no_tick = 0;
        logic prev_vo = 1'b0;
        apply_reset(3);
        for (int i = 0; i < 3203; i++) begin
            step();
            ea = model_a(n);
            vectors++;
            if (obs_a !== ea) begin
                miscompares++;
                $display("FAIL line_a n=%0d got=%h exp=%h", n, obs_a, ea);
            end
            eb = model_b(n);
            vectors++;
            if (obs_b !== eb) begin
                miscompares++;
                $display("FAIL line_b n=%0d got=%h exp=%h", n, obs_b, eb);
            end
            if (n >= 4) begin
                ticks += int'(a_p_tick);
                hs_cyc += int'(!a_hsync);
                hs_adv += int'(!a_hsync && a_p_tick);
                vo_cyc += int'(a_video_on);
                if (prev_vo && !a_video_on && fall_n < 0) fall_n = n;
            end
            prev_vo = a_video_on;
            if (n <= 800) b_hs_hi += int'(b_hsync);
            b_no_tick += int'(!b_p_tick);
        end
        vectors++;
        if (ticks != 800) begin miscompares++; $display("FAIL line_ticks got=%0d exp=800", ticks); end
        vectors++;
        if (hs_cyc != 384) begin miscompares++; $display("FAIL hsync_cycles got=%0d exp=384", hs_cyc); end
        vectors++;
        if (hs_adv != 96) begin miscompares++; $display("FAIL hsync_advances got=%0d exp=96", hs_adv); end
        vectors++;
        if (vo_cyc != 2560) begin miscompares++; $display("FAIL video_cycles got=%0d exp=2560", vo_cyc); end
        vectors++;
        if (fall_n != 2564) begin miscompares++; $display("FAIL video_fall_edge got=%0d exp=2564", fall_n); end
        vectors++;
        if (b_hs_hi != 96) begin miscompares++; $display("FAIL div1_hsync_high got=%0d exp=96", b_hs_hi); end
        vectors++;
        if (b_no_tick != 0) begin miscompares++; $display("FAIL div1_ptick_gaps got=%0d exp=0", b_no_tick); end
    endtask

    task automatic test_frame();
        int fs_n[$];
        int vs_adv = 0, vo_adv = 0, adv = 0;
        apply_reset(2);
        for (int i = 0; i < 830; i++) begin
            step();
            ec = model_c(n);
            vectors++;
            if (obs_c !== ec) begin
                miscompares++;
                $display("FAIL frame_c n=%0d got=%h exp=%h", n, obs_c, ec);
            end
            if (c_frame_start) fs_n.push_back(n);
            if (n >= 3 && n <= 407 && c_p_tick) begin
                adv++;
                vs_adv += int'(!c_vsync);
                vo_adv += int'(c_video_on);
            end
        end
        vectors++;
        if (fs_n.size() != 3 || fs_n[0] != 3 || fs_n[1] - fs_n[0] != 405) begin
            miscompares++;
            $display("FAIL frame_period count=%0d first=%0d exp count=3 first=3 period=405",
                     fs_n.size(), (fs_n.size() > 0) ? fs_n[0] : -1);
        end
        vectors++;
        if (adv != 135) begin miscompares++; $display("FAIL frame_advances got=%0d exp=135", adv); end
        vectors++;
        if (vs_adv != 30) begin miscompares++; $display("FAIL vsync_advances got=%0d exp=30", vs_adv); end
        vectors++;
        if (vo_adv != 40) begin miscompares++; $display("FAIL video_advances got=%0d exp=40", vo_adv); end
    endtask

    task automatic test_midframe_reset();
        int budget = 2000;
        apply_reset(2);
        while (a_x !== 10'd300 && budget > 0) begin
            step();
            budget--;
        end
        vectors++;
        if (budget == 0 || n != 1204) begin
            miscompares++;
            $display("FAIL reach_x300 n=%0d budget=%0d exp n=1204", n, budget);
        end
        #($urandom_range(1, 3));
        rst_n = 1'b0;
        n = 0;
        #1;
        vectors++;
        if (obs_a !== model_a(0)) begin
            miscompares++;
            $display("FAIL async_reset_a got=%h exp=%h", obs_a, model_a(0));
        end
        vectors++;
        if (obs_b !== model_b(0)) begin
            miscompares++;
            $display("FAIL async_reset_b got=%h exp=%h", obs_b, model_b(0));
        end
        vectors++;
        if (obs_c !== model_c(0)) begin
            miscompares++;
            $display("FAIL async_reset_c got=%h exp=%h", obs_c, model_c(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            ea = model_a(n);
            vectors++;
            if (obs_a !== ea) begin
                miscompares++;
                $display("FAIL restart_a n=%0d got=%h exp=%h", n, obs_a, ea);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int len;
            apply_reset($urandom_range(1, 4));
            len = $urandom_range(100, 700);
            for (int i = 0; i < len; i++) begin
                step();
                ea = model_a(n);
                eb = model_b(n);
                ec = model_c(n);
                vectors++;
                if (obs_a !== ea) begin
                    miscompares++;
                    $display("FAIL rand_a it=%0d n=%0d got=%h exp=%h", it, n, obs_a, ea);
                end
                vectors++;
                if (obs_b !== eb) begin
                    miscompares++;
                    $display("FAIL rand_b it=%0d n=%0d got=%h exp=%h", it, n, obs_b, eb);
                end
                vectors++;
                if (obs_c !== ec) begin
                    miscompares++;
                    $display("FAIL rand_c it=%0d n=%0d got=%h exp=%h", it, n, obs_c, ec);
                end
                vectors++;
                if (!(a_x < 10'd800 && a_y < 10'd525 && b_x < 10'd800 && b_y < 10'd525 &&
                      c_x < 10'd15 && c_y < 10'd9)) begin
                    miscompares++;
                    $display("FAIL rand_bounds n=%0d a=%0d,%0d b=%0d,%0d c=%0d,%0d", n,
                             a_x, a_y, b_x, b_y, c_x, c_y);
                end
            end
            #($urandom_range(1, 3));
            rst_n = 1'b0;
            n = 0;
            #1;
            vectors++;
            if (obs_c !== model_c(0)) begin
                miscompares++;
                $display("FAIL rand_reset_c it=%0d got=%h exp=%h", it, obs_c, model_c(0));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_midframe_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
